// File: rtl/fft_twiddle_mult.sv
// fft_twiddle_mult: streaming complex sample x twiddle rotation with round/saturate and frame-length check
module fft_twiddle_mult #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16,
  parameter int FRAC   = 8,
  parameter int ADDR_W = 5,
  parameter int NUM_TW = 28
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  input  logic                     in_last,
  output logic [ADDR_W-1:0]        tw_addr,
  input  logic signed [TW_W-1:0]   tw_re,
  input  logic signed [TW_W-1:0]   tw_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic                     out_last,
  output logic                     frame_err
);
  localparam int PW = DATA_W + TW_W;
  localparam int FW = PW + 1;
  localparam logic signed [FW-1:0] RND = FW'(2 ** (FRAC - 1));
  localparam logic signed [FW-1:0] HI  = FW'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [FW-1:0] LO  = ~HI;
  logic en, acc, cnt_end;
  logic [ADDR_W-1:0] cnt, s1_idx;
  logic s1_valid, s1_last, s2_valid, s2_last;
  logic signed [DATA_W-1:0] s1_re, s1_im;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [FW-1:0] re_full, im_full;
  function automatic logic signed [DATA_W-1:0] rnd_sat(input logic signed [FW-1:0] v);
    logic signed [FW-1:0] r;
    r = (v + RND) >>> FRAC;
    return r > HI ? HI[DATA_W-1:0] : r < LO ? LO[DATA_W-1:0] : r[DATA_W-1:0];
  endfunction
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign acc      = in_valid && en;
  assign cnt_end  = cnt == ADDR_W'(NUM_TW - 1);
  // while stalled the ROMs re-read the S1 index so their data stays aligned with S1
  assign tw_addr  = en ? cnt : s1_idx;
  assign re_full  = p_rr - p_ii;
  assign im_full  = p_ri + p_ir;
  // S1 capture, twiddle index counter and frame-length check
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      s1_idx    <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_re     <= '0;
      s1_im     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= acc && (in_last != cnt_end);
      if (en) begin
        s1_valid <= in_valid;
        s1_last  <= in_last;
        s1_idx   <= cnt;
        s1_re    <= in_re;
        s1_im    <= in_im;
      end
      if (acc) cnt <= (in_last || cnt_end) ? '0 : cnt + 1'b1;
    end
  end
  // S2: four partial products against the ROM data for the S1 index
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      p_rr     <= '0;
      p_ii     <= '0;
      p_ri     <= '0;
      p_ir     <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      p_rr     <= s1_re * tw_re;
      p_ii     <= s1_im * tw_im;
      p_ri     <= s1_re * tw_im;
      p_ir     <= s1_im * tw_re;
    end
  end
  // S3: combine, round half up, saturate; output held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_last <= s2_last;
        out_re   <= rnd_sat(re_full);
        out_im   <= rnd_sat(im_full);
      end
    end
  end
endmodule

// File: tb/tb_fft_twiddle_mult.sv
// tb_fft_twiddle_mult: directed vector bench for fft_twiddle_mult with a registered twiddle ROM model
module tb_fft_twiddle_mult;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_last, frame_err;
  logic [15:0] in_re = '0, in_im = '0, tw_re, tw_im, out_re, out_im;
  logic [4:0] tw_addr;
  logic [15:0] rom_re [32];
  logic [15:0] rom_im [32];
  int tests = 0, fails = 0;
  int addr_log [64];
  typedef struct {
    logic [15:0] re, im, twr, twi, ere, eim;
  } vec_t;
  vec_t v [7];
  fft_twiddle_mult dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_last(in_last), .tw_addr(tw_addr),
    .tw_re(tw_re), .tw_im(tw_im), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_last(out_last), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  // twiddle ROMs: one-cycle registered read
  always @(posedge clk) begin
    tw_re <= rom_re[tw_addr];
    tw_im <= rom_im[tw_addr];
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic longint s(input logic [15:0] x);
    return longint'($signed(x));
  endfunction
  function automatic logic [15:0] sat_rnd(input longint x);
    longint q;
    q = (x + 128) >>> 8;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return 16'(q);
  endfunction
  task automatic single(input vec_t t, input int idx);
    @(negedge clk);
    rom_re[idx] = t.twr;
    rom_im[idx] = t.twi;
    check("tw_addr_before", 32'(tw_addr), 32'(idx));
    in_valid = 1'b1; in_re = t.re; in_im = t.im; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("latency_c1", 32'(out_valid), 0);
    @(negedge clk);
    check("latency_c2", 32'(out_valid), 0);
    @(negedge clk);
    check("latency_c3_valid", 32'(out_valid), 1);
    check("out_re", 32'(out_re), 32'(t.ere));
    check("out_im", 32'(out_im), 32'(t.eim));
  endtask
  task automatic stream(input int n, input int last_pos, output int errs);
    errs = 0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (frame_err) errs++;
      in_valid = 1'b1; in_re = 16'(i); in_im = '0; in_last = (i == last_pos);
      addr_log[i] = 32'(tw_addr);
    end
    @(negedge clk);
    if (frame_err) errs++;
    in_valid = 1'b0; in_last = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (frame_err) errs++;
    end
  endtask
  initial begin
    logic [15:0] d_re [28], d_im [28], e_re [28], e_im [28];
    int sent, got, ferr, cyc, errs, s1m, cm;
    for (int i = 0; i < 32; i++) begin rom_re[i] = '0; rom_im[i] = '0; end
    v[0] = '{16'h0100, 16'h0080, 16'h0100, 16'h0000, 16'h0100, 16'h0080};
    v[1] = '{16'h8000, 16'h0000, 16'hFF00, 16'h0000, 16'h7FFF, 16'h0000};
    v[2] = '{16'h0003, 16'h0005, 16'h0080, 16'h0000, 16'h0002, 16'h0003};
    v[3] = '{16'hFFFD, 16'h0000, 16'h0080, 16'h0000, 16'hFFFF, 16'h0000};
    v[4] = '{16'h7FFF, 16'h7FFF, 16'h0100, 16'h0100, 16'h0000, 16'h7FFF};
    v[5] = '{16'h0100, 16'h0080, 16'h0000, 16'hFF00, 16'h0080, 16'hFF00};
    v[6] = '{16'h8000, 16'h8000, 16'h0100, 16'hFF00, 16'h8000, 16'h0000};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_re", 32'(out_re), 0);
    check("rst_out_im", 32'(out_im), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_tw_addr", 32'(tw_addr), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_frame_err", 32'(frame_err), 0);
    for (int i = 0; i < 7; i++) single(v[i], i);
    @(negedge clk);
    check("tw_addr_after_table", 32'(tw_addr), 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 28; i++) begin
      rom_re[i] = 16'($urandom); rom_im[i] = 16'($urandom);
      d_re[i] = 16'($urandom); d_im[i] = 16'($urandom);
      e_re[i] = sat_rnd(s(d_re[i]) * s(rom_re[i]) - s(d_im[i]) * s(rom_im[i]));
      e_im[i] = sat_rnd(s(d_re[i]) * s(rom_im[i]) + s(d_im[i]) * s(rom_re[i]));
    end
    sent = 0; got = 0; ferr = 0; cyc = 0; s1m = 0; cm = 0;
    while (got < 28 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (frame_err) ferr++;
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 28) begin
        in_valid = 1'b1; in_re = d_re[sent]; in_im = d_im[sent]; in_last = (sent == 27);
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        check("frame_re", 32'(out_re), 32'(e_re[got]));
        check("frame_im", 32'(out_im), 32'(e_im[got]));
        check("frame_last", 32'(out_last), 32'(got == 27));
        got++;
      end
      if (!in_ready) check("stall_tw_addr", 32'(tw_addr), 32'(s1m));
      else begin
        s1m = cm;
        if (in_valid) begin
          cm = (in_last || cm == 27) ? 0 : cm + 1;
          sent++;
        end
      end
    end
    check("frame_count", 32'(got), 28);
    check("frame_no_err", 32'(ferr), 0);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    check("frame_wrap_addr", 32'(tw_addr), 0);
    stream(11, 9, errs);
    check("short_addr9", 32'(addr_log[9]), 9);
    check("short_next_addr", 32'(addr_log[10]), 0);
    check("short_err_pulses", 32'(errs), 1);
    stream(28, -1, errs);
    check("long_addr0", 32'(addr_log[0]), 1);
    check("long_addr26", 32'(addr_log[26]), 27);
    check("long_29th_addr", 32'(addr_log[27]), 0);
    check("long_err_pulses", 32'(errs), 1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_re = 16'h0100; in_im = 16'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("inflight_valid", 32'(out_valid), 1);
    check("inflight_stalled", 32'(in_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    errs = 0;
    repeat (6) begin
      if (out_valid || frame_err || out_re != 0) errs++;
      @(negedge clk);
    end
    check("post_rst_quiet", 32'(errs), 0);
    single(v[0], 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
